// File: rtl/qoi_chunk_sequencer.sv
// qoi_chunk_sequencer: steps one qoi_rgb444 encoder across a camera frame.
// Gates pixels into the encoder, drains each capped chunk over valid/ready,
// clears the encoder and repeats until the frame ends. Pixels that arrive
// while the encoder cannot take them are dropped and counted.
// Optional build macro: QOI_SEQ_HDR_EN prepends a 3-byte header to every chunk.
module qoi_chunk_sequencer #(
  parameter int CHUNK_BYTES  = 320,
  parameter int FRAME_PIXELS = 76800,
  parameter int PIX_CNT_W    = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cam_vsync,
  input  logic                     pix_valid,
  input  logic [11:0]              pix_rgb,
  output logic                     enc_rst_n,
  output logic                     enc_en,
  output logic [11:0]              enc_rgb,
  input  logic                     enc_capped,
  input  logic [CHUNK_BYTES*8-1:0] enc_stream,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     out_frame_last,
  output logic [7:0]               chunk_idx,
  output logic [15:0]              drop_cnt,
  output logic                     frame_done,
  output logic                     busy
);

`ifdef QOI_SEQ_HDR_EN
  localparam int HDR_BYTES = 3;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam int DRAIN_LEN = CHUNK_BYTES + HDR_BYTES;
  localparam int DIDX_W    = $clog2(DRAIN_LEN);
  localparam int PIDX_W    = $clog2(CHUNK_BYTES);
  localparam logic [DIDX_W-1:0]    LAST_IDX  = DIDX_W'(DRAIN_LEN - 1);
  localparam logic [PIX_CNT_W-1:0] FRAME_LIM = PIX_CNT_W'(FRAME_PIXELS);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ENCODE, S_DRAIN, S_DONE} state_t;

  state_t                   state, state_d;
  logic                     vsync_q;
  logic [PIX_CNT_W-1:0]     pix_cnt;
  logic                     last_flag;
  logic [DIDX_W-1:0]        drain_idx;
  logic                     clr_frame, set_last, drop_inc;
  logic                     xfer, at_end;
  logic [15:0]              drop_cnt_d;
  logic [CHUNK_BYTES-1:0][7:0] stream_p;

  wire vsync_rise = cam_vsync & ~vsync_q;

  assign stream_p  = enc_stream;
  assign enc_rgb   = pix_rgb;
  assign enc_rst_n = rst_n & (state != S_CLEAR);
  assign busy      = (state != S_IDLE);
  assign at_end    = (drain_idx == LAST_IDX);
  assign xfer      = out_valid & out_ready;
  assign out_last       = out_valid & at_end;
  assign out_frame_last = out_valid & last_flag;
  assign drop_cnt_d = (drop_inc && drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt;

  // Next state, encoder gating, drain handshake and drop detection
  always_comb begin
    state_d    = state;
    enc_en     = 1'b0;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    clr_frame  = 1'b0;
    set_last   = 1'b0;
    drop_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (vsync_rise) begin
          state_d   = S_CLEAR;
          clr_frame = 1'b1;
        end
      end
      S_CLEAR: begin
        drop_inc = pix_valid;
        state_d  = S_ENCODE;
      end
      S_ENCODE: begin
        enc_en   = pix_valid & ~enc_capped & (pix_cnt < FRAME_LIM);
        drop_inc = pix_valid & ~enc_en;
        // A new frame or a full frame both end the frame after this chunk
        if (vsync_rise || pix_cnt == FRAME_LIM) begin
          state_d  = S_DRAIN;
          set_last = 1'b1;
        end else if (enc_capped) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        drop_inc  = pix_valid;
        set_last  = vsync_rise;
        if (out_ready && at_end) state_d = last_flag ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, frame counters and drain index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vsync_q   <= 1'b1;
      pix_cnt   <= '0;
      drop_cnt  <= '0;
      chunk_idx <= '0;
      last_flag <= 1'b0;
      drain_idx <= '0;
    end else begin
      state   <= state_d;
      vsync_q <= cam_vsync;
      if (clr_frame) begin
        pix_cnt   <= '0;
        drop_cnt  <= '0;
        chunk_idx <= '0;
        last_flag <= 1'b0;
      end else begin
        drop_cnt <= drop_cnt_d;
        if (enc_en)   pix_cnt   <= pix_cnt + 1'b1;
        if (set_last) last_flag <= 1'b1;
        if (xfer) begin
          if (at_end) begin
            drain_idx <= '0;
            if (!last_flag) chunk_idx <= chunk_idx + 8'd1;
          end else begin
            drain_idx <= drain_idx + 1'b1;
          end
        end
      end
    end
  end

`ifdef QOI_SEQ_HDR_EN
  logic              hdr_last, hdr_drop;
  logic [PIDX_W-1:0] pidx;

  assign pidx = PIDX_W'(drain_idx - DIDX_W'(HDR_BYTES));

  // Freeze header flags as the chunk enters the drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_last <= 1'b0;
      hdr_drop <= 1'b0;
    end else if (state == S_ENCODE && state_d == S_DRAIN) begin
      hdr_last <= last_flag | set_last;
      hdr_drop <= (drop_cnt_d != 16'd0);
    end
  end

  // Header bytes first, then the encoder stream
  always_comb begin
    out_byte = stream_p[pidx];
    if (drain_idx == DIDX_W'(0))      out_byte = 8'hA5;
    else if (drain_idx == DIDX_W'(1)) out_byte = chunk_idx;
    else if (drain_idx == DIDX_W'(2)) out_byte = {6'b0, hdr_drop, hdr_last};
  end
`else
  // Payload byte selected by the drain index
  always_comb begin
    out_byte = stream_p[drain_idx];
  end
`endif

endmodule

// File: tb/tb_qoi_chunk_sequencer.sv
// Randomized bench for qoi_chunk_sequencer. A toy encoder drives the DUT's
// encoder-side inputs; a transaction-level model tracks the frame and keeps
// the expected drain bytes in a queue that is popped on each handshake.
module tb_qoi_chunk_sequencer;
  localparam int CB = 16;
  localparam int FP = 12;
  localparam int PW = 5;
`ifdef QOI_SEQ_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, cam_vsync, pix_valid, out_ready;
  logic [11:0]   pix_rgb;
  logic          enc_rst_n, enc_en, enc_capped;
  logic [11:0]   enc_rgb;
  logic [CB*8-1:0] enc_stream;
  logic [7:0]    out_byte, chunk_idx;
  logic          out_valid, out_last, out_frame_last, frame_done, busy;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int failures = 0;

  qoi_chunk_sequencer #(.CHUNK_BYTES(CB), .FRAME_PIXELS(FP), .PIX_CNT_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .pix_valid(pix_valid),
    .pix_rgb(pix_rgb), .enc_rst_n(enc_rst_n), .enc_en(enc_en), .enc_rgb(enc_rgb),
    .enc_capped(enc_capped), .enc_stream(enc_stream), .out_byte(out_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_frame_last(out_frame_last), .chunk_idx(chunk_idx), .drop_cnt(drop_cnt),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // toy encoder: one byte per accepted pixel, caps after cap_lim pixels
  int         cap_lim = CB;
  int         fe_cnt;
  logic [7:0] fe_mem [CB];
  always @(posedge clk) begin
    if (!enc_rst_n) begin
      fe_cnt <= 0;
      for (int i = 0; i < CB; i++) fe_mem[i] <= 8'h00;
    end else if (enc_en) begin
      if (fe_cnt < CB) fe_mem[fe_cnt] <= enc_rgb[11:4];
      fe_cnt <= fe_cnt + 1;
    end
  end
  assign enc_capped = (fe_cnt >= cap_lim);
  always_comb for (int i = 0; i < CB; i++) enc_stream[8*i +: 8] = fe_mem[i];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  localparam int M_IDLE = 0, M_CLR = 1, M_ENC = 2, M_DRN = 3, M_DONE = 4;
  int         m_ph = M_IDLE;
  bit         m_vsq = 1'b1;
  int         m_pix = 0, m_drop = 0, m_ecnt = 0;
  logic [7:0] m_chunk = 8'h00;
  bit         m_last = 1'b0;
  logic [7:0] m_mem [CB];
  logic [7:0] exp_q [$];

  task automatic model_step();
    bit vrise, capped, e_en, drain, xfer, was_last;
    int pix_old;
    vrise  = cam_vsync && !m_vsq;
    capped = (m_ecnt >= cap_lim);
    e_en   = (m_ph == M_ENC) && pix_valid && !capped && (m_pix < FP);
    drain  = (m_ph == M_DRN);
    chk("enc_rst_n", enc_rst_n, rst_n && (m_ph != M_CLR));
    chk("enc_en", enc_en, e_en);
    chk("enc_rgb", enc_rgb, pix_rgb);
    chk("busy", busy, m_ph != M_IDLE);
    chk("out_valid", out_valid, drain);
    chk("frame_done", frame_done, m_ph == M_DONE);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("chunk_idx", chunk_idx, m_chunk);
    if (drain) begin
      if (exp_q.size() == 0) chk("drain_queue_empty", 1, 0);
      else begin
        chk("out_byte", out_byte, exp_q[0]);
        chk("out_last", out_last, exp_q.size() == 1);
        chk("out_frame_last", out_frame_last, m_last);
      end
    end else begin
      chk("out_last_idle", out_last, 0);
    end

    if (!rst_n) begin
      m_ph = M_IDLE; m_vsq = 1'b1; m_pix = 0; m_drop = 0; m_chunk = 8'h00;
      m_last = 1'b0; m_ecnt = 0; exp_q.delete();
      return;
    end
    xfer = drain && out_ready;
    if (pix_valid && (m_ph == M_CLR || m_ph == M_DRN || (m_ph == M_ENC && !e_en)) && m_drop < 65535)
      m_drop++;
    case (m_ph)
      M_IDLE: if (vrise) begin
        m_ph = M_CLR; m_pix = 0; m_drop = 0; m_chunk = 8'h00; m_last = 1'b0;
      end
      M_CLR: begin
        for (int i = 0; i < CB; i++) m_mem[i] = 8'h00;
        m_ecnt = 0;
        m_ph = M_ENC;
      end
      M_ENC: begin
        pix_old = m_pix;
        if (e_en) begin
          if (m_ecnt < CB) m_mem[m_ecnt] = pix_rgb[11:4];
          m_ecnt++; m_pix++;
        end
        if (vrise || pix_old == FP) m_last = 1'b1;
        if (vrise || pix_old == FP || capped) begin
          m_ph = M_DRN;
          if (HDR) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(m_chunk);
            exp_q.push_back({6'b0, m_drop != 0, m_last});
          end
          for (int i = 0; i < CB; i++) exp_q.push_back(m_mem[i]);
        end
      end
      M_DRN: begin
        was_last = m_last;
        if (vrise) m_last = 1'b1;
        if (xfer && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            if (was_last) m_ph = M_DONE;
            else begin m_ph = M_CLR; m_chunk = m_chunk + 8'd1; end
          end
        end
      end
      default: m_ph = M_IDLE;
    endcase
    m_vsq = cam_vsync;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    cam_vsync = 1'b0; pix_valid = 1'b0; tick();
    cam_vsync = 1'b1; tick();
  endtask

  // pv/rdy/vs in percent, rst in per-mille
  task automatic run(input int n, input int pv, input int rdy, input int vs, input int rst);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(99) < vs) cam_vsync = ~cam_vsync;
      pix_valid = ($urandom_range(99) < pv);
      pix_rgb   = 12'($urandom);
      out_ready = ($urandom_range(99) < rdy);
      rst_n     = !($urandom_range(999) < rst);
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cam_vsync = 1'b1; pix_valid = 1'b0; pix_rgb = 12'h123; out_ready = 1'b1;
    @(posedge clk); #1;
    // reset with vsync held high, then release: no frame may start
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    // full frame of constant pixels, sink always ready
    cap_lim = CB;
    vs_pulse();
    for (int k = 0; k < 40; k++) begin pix_valid = 1'b1; pix_rgb = 12'h123; tick(); end
    // same with a stalling sink
    vs_pulse();
    for (int k = 0; k < 80; k++) begin
      pix_valid = 1'b1; pix_rgb = 12'h123; out_ready = (k % 3 == 0); tick();
    end
    out_ready = 1'b1;

    // small cap: several chunks per frame with drops
    cap_lim = 5;
    vs_pulse();
    run(200, 100, 100, 0, 0);

    // vsync after a few pixels ends the frame early
    cap_lim = CB;
    vs_pulse();
    run(5, 100, 100, 0, 0);
    cam_vsync = 1'b0; tick();
    cam_vsync = 1'b1; run(60, 50, 100, 0, 0);

    // fully random: caps, stalls, vsync toggles, occasional resets
    for (int r = 0; r < 8; r++) begin
      cap_lim = $urandom_range(CB, 2);
      vs_pulse();
      run(400, 60, 70, 2, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qoi_chunk_sequencer.md
Name: qoi_chunk_sequencer

Overview:
Sequences one qoi_rgb444 encoder instance across a camera frame, sitting between the OV7670 pixel capture and the byte transport (UART/SPI framer).
- Gates pixels into the encoder and detects when its fixed-size output stream caps.
- Drains the capped chunk byte-by-byte over a valid/ready interface.
- Clears the encoder and repeats until the frame ends.
- Pixels arriving while the encoder is unavailable are dropped and counted; the camera cannot be stalled.

Parameters:
CHUNK_BYTES, 320, encoder output stream depth in bytes; sets drain length.
FRAME_PIXELS, 76800, pixels per frame (320x240); fed-pixel count that ends a frame.
PIX_CNT_W, 17, width of pixel counter; must satisfy 2^PIX_CNT_W > FRAME_PIXELS.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cam_vsync  in  1  camera vsync; rising edge = frame start
pix_valid  in  1  one-cycle pixel strobe
pix_rgb  in  12  RGB444 pixel
enc_rst_n  out  1  encoder synchronous reset
enc_en  out  1  encoder enable
enc_rgb  out  12  encoder pixel, combinational pass-through of pix_rgb
enc_capped  in  1  encoder stream full
enc_stream  in  CHUNK_BYTES*8  encoder output bytes, byte i at bits [8i+7:8i]
out_byte  out  8  drained byte
out_valid  out  1  out_byte valid
out_ready  in  1  sink accepts
out_last  out  1  final byte of chunk
out_frame_last  out  1  chunk is final chunk of frame; valid with out_valid
chunk_idx  out  8  chunk number in frame, wraps at 255
drop_cnt  out  16  pixels dropped this frame, saturating
frame_done  out  1  one-cycle pulse at end of frame
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, CLEAR, ENCODE, DRAIN, DONE.
- vsync_rise = cam_vsync & ~vsync_q.
  - vsync_q resets to 1, so vsync held high through reset is not an edge.
- IDLE -> CLEAR on vsync_rise.
  - On this transition, clear pix_cnt, drop_cnt, chunk_idx (to 0), last_flag.
- CLEAR: exactly one cycle; enc_rst_n=0 -> ENCODE.
  - enc_rst_n = rst_n & (state!=CLEAR), combinational from the state register.
- ENCODE:
  - enc_en = pix_valid & ~enc_capped & (pix_cnt < FRAME_PIXELS).
  - pix_cnt increments on enc_en.
- ENCODE exits (priority order):
  - vsync_rise -> DRAIN, set last_flag.
  - Accepted pixel makes pix_cnt==FRAME_PIXELS -> DRAIN, set last_flag; transition on the cycle after that pixel.
  - enc_capped=1 -> DRAIN.
- DRAIN:
  - out_valid=1; out_byte = enc_stream byte[drain_idx], combinational mux.
  - out_last = (drain_idx==CHUNK_BYTES-1); out_frame_last = last_flag.
  - drain_idx advances only on out_valid & out_ready; out_byte held stable while stalled.
  - Always drains all CHUNK_BYTES. Unwritten bytes are 0 because the encoder clears its stream on reset.
  - vsync_rise during DRAIN sets last_flag; takes effect from the next cycle.
- Final DRAIN transfer:
  - last_flag=1 -> DONE.
  - Otherwise -> CLEAR, chunk_idx+1, drain_idx=0.
- DONE: frame_done=1 for one cycle -> IDLE.
  - A vsync_rise in DONE is ignored; the next frame starts on a later edge.
- drop_cnt increments (saturating at 0xFFFF) on a pix_valid cycle in CLEAR, DRAIN, or ENCODE with enc_en=0.
  - Includes the cycle where enc_capped first gates a pixel.
- Reset values: state IDLE, all counters 0, out_valid 0, out_last 0, out_frame_last 0, frame_done 0, busy 0, enc_en 0, enc_rst_n 0 (while rst_n=0).
- Reset mid-operation:
  - Abandons the chunk; no out_last is emitted.
  - Encoder is reset via enc_rst_n in the same cycle.

Optional Feature:
QOI_SEQ_HDR_EN
- Defined: DRAIN first emits 3 header bytes, then the CHUNK_BYTES payload.
  - Byte 0: 0xA5.
  - Byte 1: chunk_idx.
  - Byte 2: {6'b0, drop_nonzero, last_flag}.
  - Header uses the same valid/ready handshake.
  - out_last still marks only the final payload byte.
  - last_flag/drop_nonzero are sampled on DRAIN entry.
- Undefined: no header; drain is exactly CHUNK_BYTES bytes.

Test Plan:
- FRAME_PIXELS=8, vsync pulse, 8 pixels of 0x123, out_ready=1 -> one CLEAR cycle with enc_rst_n=0; 8 enc_en pulses; 320 bytes with out_last on byte 319; out_frame_last=1, chunk_idx=0; frame_done pulse one cycle later.
- Same stimulus with out_ready toggling 1,0,0,1,... -> exactly 320 transfers; out_byte unchanged across stalled cycles; byte sequence identical to previous run.
- Random pixels every cycle until enc_capped -> DRAIN with out_frame_last=0; drop_cnt = pix_valid count from cap through the CLEAR cycle; chunk_idx=1 on the second chunk; enc_rst_n low exactly one cycle between chunks.
- vsync_rise after 5 pixels in ENCODE -> DRAIN next cycle, out_frame_last=1, pix_cnt=5, frame_done after 320 bytes.
- rst_n=0 at drain_idx=100 -> next cycle out_valid=0, busy=0, counters 0; subsequent vsync starts a clean frame at chunk_idx=0.
- QOI_SEQ_HDR_EN defined, capped chunk with drops -> bytes 0xA5, 0x00, 0x02, then 320 payload bytes, out_last on the 323rd byte.
